// File: rtl/asl_axil_pkg.sv
// Shared constants and FSM encoding for the AXI4-Lite register self-test master.
package asl_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Golden-ratio increment spreads consecutive patterns across all bits.
    localparam logic [31:0] ASL_DEFAULT_STEP = 32'h9E3779B9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_NEXT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/asl_axil_timeout_ctr.sv
// Handshake watchdog: loadable down-counter, expired once TIMEOUT enabled cycles elapse after load.
// Latency: expired is combinational from the count; load takes effect on the next edge.
// Backpressure: none; the owner gates its valids/readys with expired.
module asl_axil_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/asl_axil_selftest_master.sv
// AXI4-Lite master running a write / read-back / compare test over NUM_REGS slave registers.
// Latency: about 5 cycles per register against a zero-wait slave, plus start and finish cycles.
// Backpressure: valids hold until handshake; any handshake stalled TIMEOUT cycles aborts the run.
module asl_axil_selftest_master
    import asl_axil_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                STRIDE    = 4,
    parameter logic [31:0]       STEP      = ASL_DEFAULT_STEP,
    parameter int                TIMEOUT   = 1024
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic                mode,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [15:0]         err_count,
    output logic [7:0]          first_err_idx,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam logic [DATA_W-1:0] STEP_W   = DATA_W'(STEP);
    localparam logic [7:0]        LAST_IDX = 8'(NUM_REGS - 1);

    state_t              state, next_state;
    logic [7:0]          idx;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   pat_q, seed_q;
    logic                mode_q, rd_phase, aw_done, w_done;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                last_idx, err_inc;
    logic                tmo_load, tmo_en, tmo_exp;

    assign aw_hs    = m_axi_awvalid && m_axi_awready;
    assign w_hs     = m_axi_wvalid && m_axi_wready;
    assign b_hs     = m_axi_bvalid && m_axi_bready;
    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_hs     = m_axi_rvalid && m_axi_rready;
    assign last_idx = (idx == LAST_IDX);

    // A read counts at most once even when both the response and the data are bad.
    assign err_inc = (b_hs && (m_axi_bresp != RESP_OKAY)) ||
                     (r_hs && ((m_axi_rresp != RESP_OKAY) || (m_axi_rdata != pat_q)));

    assign tmo_load = (next_state != state);
    assign tmo_en   = (state == ST_WR) || (state == ST_WB) || (state == ST_RA) || (state == ST_RD);

    asl_axil_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_WR;
            ST_WR: begin
                if (tmo_exp)                                          next_state = ST_FIN;
                else if ((aw_done || aw_hs) && (w_done || w_hs))      next_state = ST_WB;
            end
            ST_WB: begin
                if (tmo_exp)   next_state = ST_FIN;
                else if (b_hs) next_state = mode_q ? ST_NEXT : ST_RA;
            end
            ST_RA: begin
                if (tmo_exp)    next_state = ST_FIN;
                else if (ar_hs) next_state = ST_RD;
            end
            ST_RD: begin
                if (tmo_exp)   next_state = ST_FIN;
                else if (r_hs) next_state = ST_NEXT;
            end
            ST_NEXT: begin
                if (last_idx) next_state = (mode_q && !rd_phase) ? ST_RA : ST_FIN;
                else          next_state = (mode_q && rd_phase)  ? ST_RA : ST_WR;
            end
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = (state == ST_WR) && !aw_done && !tmo_exp;
        m_axi_wvalid  = (state == ST_WR) && !w_done && !tmo_exp;
        m_axi_bready  = (state == ST_WB) && !tmo_exp;
        m_axi_arvalid = (state == ST_RA) && !tmo_exp;
        m_axi_rready  = (state == ST_RD) && !tmo_exp;
        busy          = (state != ST_IDLE) && (state != ST_FIN);
        done          = (state == ST_FIN);
    end

    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = pat_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = '1;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            idx           <= '0;
            addr_q        <= BASE_ADDR;
            pat_q         <= '0;
            seed_q        <= '0;
            mode_q        <= 1'b0;
            rd_phase      <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 8'hFF;
            pass          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                idx           <= '0;
                addr_q        <= BASE_ADDR;
                pat_q         <= seed;
                seed_q        <= seed;
                mode_q        <= mode;
                rd_phase      <= 1'b0;
                err_count     <= '0;
                first_err_idx <= 8'hFF;
                pass          <= 1'b0;
                timeout       <= 1'b0;
            end

            if ((next_state == ST_WR) && (state != ST_WR)) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            if (err_inc) begin
                if (err_count == '0)      first_err_idx <= idx;
                if (err_count != 16'hFFFF) err_count    <= err_count + 16'd1;
            end

            if (tmo_exp) timeout <= 1'b1;

            // Batch mode rewinds index, address and pattern once the write pass ends.
            if (state == ST_NEXT) begin
                if (last_idx) begin
                    if (mode_q && !rd_phase) begin
                        rd_phase <= 1'b1;
                        idx      <= '0;
                        addr_q   <= BASE_ADDR;
                        pat_q    <= seed_q;
                    end
                end else begin
                    idx    <= idx + 8'd1;
                    addr_q <= addr_q + ADDR_W'(STRIDE);
                    pat_q  <= pat_q + STEP_W;
                end
            end

            if ((next_state == ST_FIN) && (state != ST_FIN)) begin
                pass <= !tmo_exp && (err_count == '0);
            end
        end
    end

endmodule

// File: tb/tb_asl_axil_selftest_master.sv
// Bench for the self-test master: register-file slave with optional stalls, read corruption and
// a silent write-response channel, plus an in-order model of the expected bus traffic and results.
module tb_asl_axil_selftest_master;
    import asl_axil_pkg::*;

    localparam int          NUM_REGS = 4;
    localparam int          TMO      = 16;
    localparam logic [31:0] STEP_C   = 32'h9E3779B9;

    logic        tb_ACLK = 1'b0;
    logic        ARESET, start, mode;
    logic [31:0] seed;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [7:0]  first_err_idx;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 tb_ACLK = ~tb_ACLK;

    asl_axil_selftest_master #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGS(NUM_REGS), .BASE_ADDR(32'h0),
        .STRIDE(4), .STEP(STEP_C), .TIMEOUT(TMO)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc_now = 0;
    int          w_hs_cyc = 0;
    logic [31:0] regs [4];
    int          stall_max;
    bit          flip_en, nob_en, run_mode;
    bit          aw_have, w_have, ar_have;
    logic [31:0] aw_addr_c, w_data_c, ar_addr_c;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit          p_awv, p_wv, p_arv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
    int          aw_cnt, ar_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int rnd_wait();
        return (stall_max == 0) ? 0 : int'($urandom_range(stall_max, 0));
    endfunction

    // Slave and traffic checker; runs once per negedge, between active edges.
    task automatic slave_step();
        logic [31:0] rd;
        if (ARESET) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_have = 0; w_have = 0; ar_have = 0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
            return;
        end
        if (hs_aw) begin aw_have = 1; m_axi_awready = 0; aw_wait = rnd_wait(); end
        if (hs_w)  begin w_have = 1;  m_axi_wready = 0;  w_wait = rnd_wait();  end
        if (hs_b)  begin m_axi_bvalid = 0; b_wait = rnd_wait(); end
        if (hs_ar) begin ar_have = 1; m_axi_arready = 0; ar_wait = rnd_wait(); end
        if (hs_r)  begin m_axi_rvalid = 0; r_wait = rnd_wait(); end

        if (p_awv && !hs_aw) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
        if (p_wv && !hs_w)   chk("w_hold", {m_axi_wvalid, m_axi_wdata}, {1'b1, p_wdata});
        if (p_arv && !hs_ar) chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});

        if (m_axi_awvalid && !aw_have && !m_axi_awready) begin
            if (aw_wait > 0) aw_wait--; else m_axi_awready = 1;
        end
        if (m_axi_wvalid && !w_have && !m_axi_wready) begin
            if (w_wait > 0) w_wait--; else m_axi_wready = 1;
        end
        if (aw_have && w_have && !m_axi_bvalid && !nob_en) begin
            if (b_wait > 0) b_wait--;
            else begin
                regs[aw_addr_c[3:2]] = w_data_c;
                m_axi_bvalid = 1; m_axi_bresp = RESP_OKAY;
                aw_have = 0; w_have = 0;
            end
        end
        if (m_axi_arvalid && !ar_have && !m_axi_arready) begin
            if (ar_wait > 0) ar_wait--; else m_axi_arready = 1;
        end
        if (ar_have && !m_axi_rvalid) begin
            if (r_wait > 0) r_wait--;
            else begin
                rd = regs[ar_addr_c[3:2]];
                if (flip_en && ar_addr_c[3:2] == 2'd2) rd[0] = ~rd[0];
                m_axi_rdata = rd; m_axi_rresp = RESP_OKAY; m_axi_rvalid = 1;
                ar_have = 0;
            end
        end

        hs_aw = m_axi_awvalid && m_axi_awready;
        hs_w  = m_axi_wvalid && m_axi_wready;
        hs_b  = m_axi_bvalid && m_axi_bready;
        hs_ar = m_axi_arvalid && m_axi_arready;
        hs_r  = m_axi_rvalid && m_axi_rready;
        if (hs_aw) begin
            aw_addr_c = m_axi_awaddr;
            chk("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) chk("awaddr", m_axi_awaddr, exp_aw.pop_front());
            chk("awprot", m_axi_awprot, 3'b000);
            aw_cnt++;
        end
        if (hs_w) begin
            w_data_c = m_axi_wdata;
            w_hs_cyc = cyc_now;
            chk("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) chk("wdata", m_axi_wdata, exp_w.pop_front());
            chk("wstrb", m_axi_wstrb, 4'hF);
        end
        if (hs_ar) begin
            ar_addr_c = m_axi_araddr;
            chk("ar_expected", exp_ar.size() > 0, 1);
            if (exp_ar.size() > 0) chk("araddr", m_axi_araddr, exp_ar.pop_front());
            chk("arprot", m_axi_arprot, 3'b000);
            chk("ar_order", aw_cnt, run_mode ? NUM_REGS : ar_cnt + 1);
            ar_cnt++;
        end
        p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
        p_wv  = m_axi_wvalid;  p_wdata  = m_axi_wdata;
        p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
    endtask

    task automatic tick();
        @(negedge tb_ACLK);
        cyc_now++;
        slave_step();
    endtask

    task automatic arm(input bit md, input logic [31:0] sd, input int smax, input bit flip, input bit nob);
        stall_max = smax; flip_en = flip; nob_en = nob; run_mode = md;
        aw_have = 0; w_have = 0; ar_have = 0; aw_cnt = 0; ar_cnt = 0;
        aw_wait = rnd_wait(); w_wait = rnd_wait(); b_wait = rnd_wait();
        ar_wait = rnd_wait(); r_wait = rnd_wait();
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_aw.push_back(32'(i * 4));
            exp_w.push_back(sd + 32'(i) * STEP_C);
            exp_ar.push_back(32'(i * 4));
        end
        mode = md; seed = sd;
    endtask

    task automatic run(input string tag, input bit md, input logic [31:0] sd, input int smax,
                       input bit flip, input bit nob, input logic [15:0] exp_err,
                       input logic [7:0] exp_first, input bit exp_tmo, input int lat_max);
        int cyc;
        bit exp_pass;
        exp_pass = (exp_err == 0) && !exp_tmo;
        arm(md, sd, smax, flip, nob);
        start = 1;
        tick();
        start = 0;
        seed = ~sd;
        cyc = 1;
        while (!done && cyc < lat_max + 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, cyc <= lat_max, 1);
        chk({tag, "_pass"}, pass, exp_pass);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_first_err"}, first_err_idx, exp_first);
        chk({tag, "_timeout"}, timeout, exp_tmo);
        chk({tag, "_busy_at_done"}, busy, 0);
        if (nob) chk({tag, "_tmo_window"}, (cyc_now - w_hs_cyc) <= 20, 1);
        else     chk({tag, "_all_regs"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_pass_held"}, pass, exp_pass);
    endtask

    initial begin
        int n;
        ARESET = 1; start = 0; mode = 0; seed = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
        for (int i = 0; i < 4; i++) regs[i] = '0;
        stall_max = 0; flip_en = 0; nob_en = 0; run_mode = 0;
        repeat (3) tick();
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("rst_status", {busy, done, pass, timeout}, 4'b0);
        chk("rst_err_count", err_count, 16'h0);
        chk("rst_first_err", first_err_idx, 8'hFF);
        ARESET = 0;
        tick();

        run("inter", 0, 32'h0101FFFF, 0, 0, 0, 16'd0, 8'hFF, 0, 7 * NUM_REGS + 2);
        chk("pat0", regs[0], 32'h0101FFFF);
        chk("pat1", regs[1], 32'h9F3979B8);
        chk("pat2", regs[2], 32'h3D70F371);
        chk("pat3", regs[3], 32'hDBA86D2A);

        run("batch", 1, 32'h0101FFFF, 0, 0, 0, 16'd0, 8'hFF, 0, 7 * NUM_REGS + 2);
        run("flip", 0, 32'h12345678, 0, 1, 0, 16'd1, 8'h02, 0, 7 * NUM_REGS + 2);
        run("stall_i", 0, 32'hA5A50F0F, 7, 0, 0, 16'd0, 8'hFF, 0, 600);
        run("stall_b", 1, 32'h5A5AF0F0, 7, 0, 0, 16'd0, 8'hFF, 0, 600);
        run("stall_f", 1, 32'hFFFFFFFF, 7, 1, 0, 16'd1, 8'h02, 0, 600);
        run("no_bvalid", 0, 32'h00000001, 0, 0, 1, 16'd0, 8'hFF, 1, 40);

        arm(0, 32'hCAFE0001, 0, 0, 0);
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (!(m_axi_rready && m_axi_araddr == 32'h4) && n < 100) begin
            tick();
            n++;
        end
        chk("rd1_reached", n < 100, 1);
        ARESET = 1;
        #1;
        chk("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("midrst_status", {busy, done, pass, timeout}, 4'b0);
        chk("midrst_err_count", err_count, 16'h0);
        chk("midrst_first_err", first_err_idx, 8'hFF);
        repeat (2) begin
            tick();
            chk("midrst_quiet", {done, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready}, 5'b0);
        end
        ARESET = 0;
        tick();
        run("post_rst", 0, 32'h0BADF00D, 0, 0, 0, 16'd0, 8'hFF, 0, 7 * NUM_REGS + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
